// File: rtl/node_frame_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : node_frame_loader_if
//  Description : Valid/ready word stream feeding node_frame_loader.
//                One signed word moves per rising edge when s_valid and
//                s_ready are both high.
//  Signals     : s_valid  - word on s_data is valid         (master -> slave)
//                s_data   - signed stream word, INPUT_SIZE   (master -> slave)
//                s_ready  - slave can take a word this cycle (slave -> master)
//  Modports    : master (stream source), slave (loader)
//  Revision    : 1.0 - initial release
// ============================================================================
interface node_frame_loader_if #(
    parameter int INPUT_SIZE = 6
) ();

    logic                          s_valid;
    logic                          s_ready;
    logic signed [INPUT_SIZE-1:0]  s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface : node_frame_loader_if
`default_nettype wire

// File: rtl/node_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : node_frame_loader
//  Description : Upstream feeder for the GNN node compute stage. Collects a
//                serial stream of signed words into a shadow buffer (features
//                x0..x3 followed by 24 weights), then commits the whole frame
//                to held output registers together with a one-cycle in_ready
//                pulse. Two commits are never closer than HOLD_CYCLES edges
//                so the node's pipeline sees stable output-layer weights.
//
//  Parameters  : INPUT_SIZE   feature width, also the stream word width
//                WEIGHT_SIZE  weight width, taken from s_data[WEIGHT_SIZE-1:0]
//                HOLD_CYCLES  minimum edges between two commits (>= 1)
//
//  Ports       : clk            rising-edge clock
//                rst_n          asynchronous active-low reset
//                clear          synchronous drop of the partial frame
//                s (slave)      word stream: s_valid / s_ready / s_data
//                x0..x3         committed features (signed)
//                w04..w37       committed hidden weights (16)
//                w48..w79       committed output weights (8)
//                in_ready       one-cycle pulse marking a new frame on x*/w*
//                load_weights   only with NODE_LOADER_WEIGHT_CACHE_EN
//
//  Build macro : NODE_LOADER_WEIGHT_CACHE_EN
//                Defined  : load_weights is sampled with the first word of a
//                           frame. 0 -> 4-word frame, only x0..x3 update and
//                           the committed weights are kept. 1 -> 28 words.
//                Undefined: load_weights is absent, every frame is 28 words.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module node_frame_loader #(
    parameter int INPUT_SIZE  = 6,
    parameter int WEIGHT_SIZE = 5,
    parameter int HOLD_CYCLES = 4
) (
    input  wire                           clk,
    input  wire                           rst_n,
    input  wire                           clear,
`ifdef NODE_LOADER_WEIGHT_CACHE_EN
    input  wire                           load_weights,
`endif
    node_frame_loader_if.slave            s,

    output logic signed [INPUT_SIZE-1:0]  x0,
    output logic signed [INPUT_SIZE-1:0]  x1,
    output logic signed [INPUT_SIZE-1:0]  x2,
    output logic signed [INPUT_SIZE-1:0]  x3,

    output logic signed [WEIGHT_SIZE-1:0] w04,
    output logic signed [WEIGHT_SIZE-1:0] w05,
    output logic signed [WEIGHT_SIZE-1:0] w06,
    output logic signed [WEIGHT_SIZE-1:0] w07,
    output logic signed [WEIGHT_SIZE-1:0] w14,
    output logic signed [WEIGHT_SIZE-1:0] w15,
    output logic signed [WEIGHT_SIZE-1:0] w16,
    output logic signed [WEIGHT_SIZE-1:0] w17,
    output logic signed [WEIGHT_SIZE-1:0] w24,
    output logic signed [WEIGHT_SIZE-1:0] w25,
    output logic signed [WEIGHT_SIZE-1:0] w26,
    output logic signed [WEIGHT_SIZE-1:0] w27,
    output logic signed [WEIGHT_SIZE-1:0] w34,
    output logic signed [WEIGHT_SIZE-1:0] w35,
    output logic signed [WEIGHT_SIZE-1:0] w36,
    output logic signed [WEIGHT_SIZE-1:0] w37,

    output logic signed [WEIGHT_SIZE-1:0] w48,
    output logic signed [WEIGHT_SIZE-1:0] w58,
    output logic signed [WEIGHT_SIZE-1:0] w49,
    output logic signed [WEIGHT_SIZE-1:0] w59,
    output logic signed [WEIGHT_SIZE-1:0] w68,
    output logic signed [WEIGHT_SIZE-1:0] w69,
    output logic signed [WEIGHT_SIZE-1:0] w78,
    output logic signed [WEIGHT_SIZE-1:0] w79,

    output logic                          in_ready
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int            NUM_X       = 4;
    localparam int            NUM_W       = 24;
    localparam logic [4:0]    IDX_LAST    = 5'd27;   // last word of a full frame
    localparam logic [4:0]    IDX_LAST_X  = 5'd3;    // last word of a feature-only frame
    localparam logic [4:0]    IDX_FIRST_W = 5'd4;    // first weight word

    // Counter only has to hold HOLD_CYCLES-1.
    localparam int            HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [0:0]    ST_FILL        = 1'b0;
    localparam logic [0:0]    ST_COMMIT_WAIT = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]                    state_q,    state_d;
    logic [4:0]                    idx_q,      idx_d;
    logic [HOLD_W-1:0]             hold_cnt_q, hold_cnt_d;
    logic                          in_ready_q, in_ready_d;

    logic signed [INPUT_SIZE-1:0]  shadow_x_q [NUM_X];
    logic signed [INPUT_SIZE-1:0]  shadow_x_d [NUM_X];
    logic signed [WEIGHT_SIZE-1:0] shadow_w_q [NUM_W];
    logic signed [WEIGHT_SIZE-1:0] shadow_w_d [NUM_W];

    logic signed [INPUT_SIZE-1:0]  x_q [NUM_X];
    logic signed [INPUT_SIZE-1:0]  x_d [NUM_X];
    logic signed [WEIGHT_SIZE-1:0] w_q [NUM_W];
    logic signed [WEIGHT_SIZE-1:0] w_d [NUM_W];

`ifdef NODE_LOADER_WEIGHT_CACHE_EN
    logic                          full_frame_q, full_frame_d;
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                          w_s_ready;
    logic                          w_commit;
    logic                          w_xfer;
    logic                          w_frame_full;
    logic                          w_last_word;
    logic [4:0]                    w_last_idx;
    logic [4:0]                    w_widx;

`ifdef NODE_LOADER_WEIGHT_CACHE_EN
    // The frame length is fixed by the load_weights value captured with
    // word 0; idx 0 is never the last word, so the registered copy is
    // always valid by the time it is needed.
    assign w_frame_full = full_frame_q;
`else
    assign w_frame_full = 1'b1;
`endif

    assign w_last_idx  = w_frame_full ? IDX_LAST : IDX_LAST_X;
    assign w_last_word = (idx_q == w_last_idx);
    assign w_widx      = idx_q - IDX_FIRST_W;

    // clear takes priority over a coincident transfer: the word is dropped.
    assign w_xfer      = s.s_valid && w_s_ready && !clear;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (w_xfer && w_last_word) begin
                    state_d = ST_COMMIT_WAIT;
                end
            end
            ST_COMMIT_WAIT: begin
                if (w_commit) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
        // A clear in the wait state abandons the completed-but-uncommitted
        // frame; a commit on the same edge still goes through.
        if (clear) begin
            state_d = ST_FILL;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_s_ready = 1'b0;
        w_commit  = 1'b0;
        case (state_q)
            ST_FILL:        w_s_ready = rst_n;   // held low throughout reset
            ST_COMMIT_WAIT: w_commit  = (hold_cnt_q == '0);
            default: begin
                w_s_ready = 1'b0;
                w_commit  = 1'b0;
            end
        endcase
    end

    assign s.s_ready = w_s_ready;

    // ------------------------------------------------------------------------
    // Datapath: shadow fill, commit, hold counter
    // ------------------------------------------------------------------------
    always_comb begin
        idx_d        = idx_q;
        hold_cnt_d   = hold_cnt_q;
        in_ready_d   = 1'b0;
        shadow_x_d   = shadow_x_q;
        shadow_w_d   = shadow_w_q;
        x_d          = x_q;
        w_d          = w_q;
`ifdef NODE_LOADER_WEIGHT_CACHE_EN
        full_frame_d = full_frame_q;
`endif

        if (w_xfer) begin
            if (idx_q < IDX_FIRST_W) begin
                shadow_x_d[idx_q[1:0]] = s.s_data;
            end else begin
                // Weight words keep only their low bits.
                shadow_w_d[w_widx] = s.s_data[WEIGHT_SIZE-1:0];
            end
            idx_d = w_last_word ? 5'd0 : (idx_q + 5'd1);
`ifdef NODE_LOADER_WEIGHT_CACHE_EN
            if (idx_q == 5'd0) begin
                full_frame_d = load_weights;
            end
`endif
        end

        if (clear) begin
            idx_d = 5'd0;
        end

        if (w_commit) begin
            x_d = shadow_x_q;
            if (w_frame_full) begin
                w_d = shadow_w_q;
            end
            in_ready_d = 1'b1;
            hold_cnt_d = HOLD_RELOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= 5'd0;
            hold_cnt_q   <= '0;
            in_ready_q   <= 1'b0;
            shadow_x_q   <= '{default: '0};
            shadow_w_q   <= '{default: '0};
            x_q          <= '{default: '0};
            w_q          <= '{default: '0};
`ifdef NODE_LOADER_WEIGHT_CACHE_EN
            full_frame_q <= 1'b1;
`endif
        end else begin
            idx_q        <= idx_d;
            hold_cnt_q   <= hold_cnt_d;
            in_ready_q   <= in_ready_d;
            shadow_x_q   <= shadow_x_d;
            shadow_w_q   <= shadow_w_d;
            x_q          <= x_d;
            w_q          <= w_d;
`ifdef NODE_LOADER_WEIGHT_CACHE_EN
            full_frame_q <= full_frame_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping, in frame order
    // ------------------------------------------------------------------------
    assign in_ready = in_ready_q;

    assign x0  = x_q[0];
    assign x1  = x_q[1];
    assign x2  = x_q[2];
    assign x3  = x_q[3];

    assign w04 = w_q[0];
    assign w05 = w_q[1];
    assign w06 = w_q[2];
    assign w07 = w_q[3];
    assign w14 = w_q[4];
    assign w15 = w_q[5];
    assign w16 = w_q[6];
    assign w17 = w_q[7];
    assign w24 = w_q[8];
    assign w25 = w_q[9];
    assign w26 = w_q[10];
    assign w27 = w_q[11];
    assign w34 = w_q[12];
    assign w35 = w_q[13];
    assign w36 = w_q[14];
    assign w37 = w_q[15];

    assign w48 = w_q[16];
    assign w58 = w_q[17];
    assign w49 = w_q[18];
    assign w59 = w_q[19];
    assign w68 = w_q[20];
    assign w69 = w_q[21];
    assign w78 = w_q[22];
    assign w79 = w_q[23];

endmodule : node_frame_loader
`default_nettype wire

// File: tb/tb_node_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_node_frame_loader
//  Description : Directed self-checking bench for node_frame_loader.
//                Frames are described by small pattern functions; expected
//                outputs are the pattern values placed in frame order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_node_frame_loader;

    localparam int IS   = 6;
    localparam int WS   = 5;
    localparam int HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
`ifdef NODE_LOADER_WEIGHT_CACHE_EN
    logic load_weights = 1'b1;
`endif

    always #5 clk = ~clk;

    node_frame_loader_if #(.INPUT_SIZE(IS)) s_if ();

    logic [IS-1:0] x_out [4];
    logic [WS-1:0] w_out [24];
    logic          in_ready;

    node_frame_loader #(
        .INPUT_SIZE  (IS),
        .WEIGHT_SIZE (WS),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
`ifdef NODE_LOADER_WEIGHT_CACHE_EN
        .load_weights (load_weights),
`endif
        .s            (s_if.slave),
        .x0  (x_out[0]),  .x1  (x_out[1]),  .x2  (x_out[2]),  .x3  (x_out[3]),
        .w04 (w_out[0]),  .w05 (w_out[1]),  .w06 (w_out[2]),  .w07 (w_out[3]),
        .w14 (w_out[4]),  .w15 (w_out[5]),  .w16 (w_out[6]),  .w17 (w_out[7]),
        .w24 (w_out[8]),  .w25 (w_out[9]),  .w26 (w_out[10]), .w27 (w_out[11]),
        .w34 (w_out[12]), .w35 (w_out[13]), .w36 (w_out[14]), .w37 (w_out[15]),
        .w48 (w_out[16]), .w58 (w_out[17]), .w49 (w_out[18]), .w59 (w_out[19]),
        .w68 (w_out[20]), .w69 (w_out[21]), .w78 (w_out[22]), .w79 (w_out[23]),
        .in_ready     (in_ready)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping: edge counter and in_ready pulse log, sampled 2ns after
    // each rising edge (inputs are driven and checked on falling edges).
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc [64];
    int stalls = 0;
    int last_word_cyc = 0;

    always @(posedge clk) begin
        #2;
        cyc <= cyc + 1;
        if (in_ready && pulse_cnt < 64) begin
            pulse_cyc[pulse_cnt] <= cyc + 1;
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Frame patterns: word i of pattern p
    // ------------------------------------------------------------------------
    function automatic logic [IS-1:0] pat(input int p, input int i);
        logic [IS-1:0] v;
        case (p)
            0: begin
                case (i)
                    0:       v = 6'h3D;          // -3
                    1:       v = 6'h05;          //  5
                    2:       v = 6'h1F;          // 31
                    3:       v = 6'h20;          // -32
                    4:       v = 6'h30;          // -16 (w04 reads 5'h10)
                    default: v = IS'(i % 16);
                endcase
            end
            1:       v = IS'((i * 3 + 1) % 64);
            2:       v = IS'(63 - i);
            3:       v = IS'(i ^ 21);
            4:       v = 6'h2A;
            5:       v = IS'((i + 7) % 64);
            6:       v = IS'((i * 5) % 64);
            7:       v = IS'((i * 9 + 2) % 64);
            default: v = IS'((p * 7 + i * 13) % 64);
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check x0..x3 against pattern px and the 24 weights against pattern pw.
    task automatic check_frame(input string tag, input int px, input int pw);
        logic [IS-1:0] e;
        for (int i = 0; i < 4; i++) begin
            e = pat(px, i);
            check($sformatf("%s_x%0d", tag, i), 32'(x_out[i]), 32'(e));
        end
        for (int k = 0; k < 24; k++) begin
            e = pat(pw, k + 4);
            check($sformatf("%s_w%0d", tag, k), 32'(w_out[k]), 32'(e[WS-1:0]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_x%0d", tag, i), 32'(x_out[i]), 32'd0);
        for (int k = 0; k < 24; k++)
            check($sformatf("%s_w%0d", tag, k), 32'(w_out[k]), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_s_ready"}, 32'(s_if.s_ready), 32'd0);
    endtask

    // Called on a falling edge; returns on the falling edge after the word
    // was accepted, with last_word_cyc = number of the accepting edge.
    task automatic send_word(input logic [IS-1:0] d);
        int guard;
        guard = 0;
        while (s_if.s_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
            stalls++;
        end
        if (guard >= 100) check("s_ready_timeout", 32'(s_if.s_ready), 32'd1);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        @(negedge clk);
        s_if.s_valid = 1'b0;
        last_word_cyc = cyc;
    endtask

    task automatic send_frame(input int p, input int n);
        for (int i = 0; i < n; i++) send_word(pat(p, i));
    endtask

    int p0;
    int n;

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;

        // ---------------- Reset state ----------------
        #1 rst_n = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(s_if.s_ready), 32'd1);

        // ---------------- 1: single frame, continuous valid ----------------
        p0 = pulse_cnt;
        send_frame(0, 28);
        n = last_word_cyc;
        check("t1_no_early_pulse", 32'(in_ready), 32'd0);
        check("t1_ready_low_wait", 32'(s_if.s_ready), 32'd0);
        @(negedge clk);
        check("t1_pulse", 32'(in_ready), 32'd1);
        check("t1_pulse_edge", 32'(pulse_cyc[p0]), 32'(n + 1));
        check_frame("t1", 0, 0);
        @(negedge clk);
        check("t1_pulse_width", 32'(in_ready), 32'd0);
        check("t1_pulse_count", 32'(pulse_cnt), 32'(p0 + 1));

        // ---------------- 2: back-to-back frames ----------------
        p0 = pulse_cnt;
        send_frame(1, 28);
        stalls = 0;
        send_frame(2, 28);
        check("t2_stall_cycles", 32'(stalls), 32'd1);
        check("t2_ready_low_wait", 32'(s_if.s_ready), 32'd0);
        @(negedge clk);
        check("t2_pulse", 32'(in_ready), 32'd1);
        check("t2_pulse_count", 32'(pulse_cnt), 32'(p0 + 2));
        check("t2_pulse_spacing", 32'(pulse_cyc[p0 + 1] - pulse_cyc[p0]), 32'd29);
        check_frame("t2", 2, 2);

        // ---------------- 3: s_valid toggling ----------------
        p0 = pulse_cnt;
        for (int i = 0; i < 28; i++) begin
            send_word(pat(3, i));
            if (i < 27) @(negedge clk);
        end
        n = last_word_cyc;
        @(negedge clk);
        check("t3_pulse_count", 32'(pulse_cnt), 32'(p0 + 1));
        check("t3_pulse_edge", 32'(pulse_cyc[p0]), 32'(n + 1));
        check_frame("t3", 3, 3);

        // ---------------- 4: clear at idx 10 ----------------
        p0 = pulse_cnt;
        send_frame(4, 10);
        clear        = 1'b1;
        s_if.s_valid = 1'b1;      // dropped: clear wins
        s_if.s_data  = 6'h11;
        @(negedge clk);
        clear        = 1'b0;
        s_if.s_valid = 1'b0;
        send_frame(5, 28);
        @(negedge clk);
        check("t4_pulse_count", 32'(pulse_cnt), 32'(p0 + 1));
        check_frame("t4", 5, 5);

        // ---------------- 5: reset mid-frame ----------------
        send_frame(6, 15);
        #2 rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_ready_after_reset", 32'(s_if.s_ready), 32'd1);
        p0 = pulse_cnt;
        send_frame(7, 28);
        @(negedge clk);
        check("t5_pulse_count", 32'(pulse_cnt), 32'(p0 + 1));
        check_frame("t5", 7, 7);

`ifdef NODE_LOADER_WEIGHT_CACHE_EN
        // ---------------- 6: weight cache, feature-only frames ----------------
        load_weights = 1'b1;
        send_frame(8, 28);
        @(negedge clk);
        check_frame("t6_full", 8, 8);
        p0 = pulse_cnt;
        load_weights = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(9 + f, 4);
        @(negedge clk);
        check("t6_pulse_count", 32'(pulse_cnt), 32'(p0 + 4));
        // Four transfers plus the commit cycle per short frame.
        for (int f = 1; f < 4; f++)
            check($sformatf("t6_spacing%0d", f),
                  32'(pulse_cyc[p0 + f] - pulse_cyc[p0 + f - 1]), 32'd5);
        check_frame("t6_short", 12, 8);
        load_weights = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_node_frame_loader
`default_nettype wire
